arith_issue_ctrl: RTL
=====================

Name: arith_issue_ctrl

Overview:
- Front-end and back-end shell for the 3-stage `pipeline_arithmetic` datapath.
- Upstream side: accepts operation commands over a valid/ready handshake and drives the unit's A/B/op_select inputs, one op per clock.
- Downstream side: tracks each op through the unit's fixed latency and captures the matching result, tagged with opcode and divide-by-zero error, into an output FIFO.
- Credit-based issue prevents FIFO overflow under downstream backpressure.

Parameters:
- RESULT_LAT, 3, clk edges from the edge that updates A/B/op_select to the edge at which the matching result is captured.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; also drives the arithmetic unit's reset.
- s_valid  in  1  command valid.
- s_ready  out  1  command accepted when s_valid & s_ready at a rising edge.
- s_a  in  8  operand A.
- s_b  in  8  operand B.
- s_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- A  out  8  to arithmetic unit; registered.
- B  out  8  to arithmetic unit; registered.
- op_select  out  2  to arithmetic unit; registered.
- result  in  16  from arithmetic unit.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer accepts head.
- m_result  out  16  head result.
- m_op  out  2  head opcode.
- m_err  out  1  head was divide with B==0.
- busy  out  1  in-flight ops or FIFO not empty.

Behaviour:
- Reset (sync, high):
  - A=0, B=0, op_select=00.
  - Valid/tag shift register cleared; FIFO pointers and count = 0.
  - m_valid=0, m_result=0, m_op=00, m_err=0, busy=0.
  - Reset mid-operation discards all in-flight ops and FIFO contents; no result produced for them.
- Issue:
  - On accept, register A←s_a, B←s_b, op_select←s_op.
  - Push tag {valid=1, op=s_op, err=(s_op==11 && s_b==0)} into the tag shift register, length RESULT_LAT.
  - Cycle without accept: A=0, B=0, op_select=00 (bubble), tag valid=0.
  - Throughput: one op per cycle.
- Credit:
  - inflight = number of valid tags in the shift register.
  - s_ready = (fifo_count + inflight) < FIFO_DEPTH, computed from registered state only; no combinational path from s_valid or m_ready.
  - A pop in the current cycle does not raise s_ready until the next cycle.
  - s_ready=0 during reset.
- Capture:
  - When the tag at shift-register position RESULT_LAT-1 is valid, push {result, op, err} into the FIFO on that edge.
  - result passes unmodified, including whatever the unit outputs for divide by zero; consumers use m_err.
  - Capture never finds the FIFO full (guaranteed by credit); the bench asserts this.
- FIFO, first-word fall-through:
  - m_valid = (count != 0); head fields present while m_valid.
  - m_result, m_op, m_err hold their last value when empty.
  - Pop on m_valid & m_ready.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering: results leave in issue order; no reordering or drop.
- busy = (inflight != 0) || (count != 0).
- Latency: accept at edge k → A/B/op_select valid after edge k → result captured at edge k+RESULT_LAT → m_valid high after edge k+RESULT_LAT when the FIFO was empty.

Test Plan:
- Back-to-back, m_ready=1: issue (5,3,00), (10,4,01), (12,2,10), (8,2,11) on consecutive cycles → m_result 8, 6, 24, 4 in order on 4 consecutive cycles, m_err=0, first m_valid RESULT_LAT cycles after first accept.
- Divide by zero: (15,0,11) → m_op=11, m_err=1, m_valid asserted; next op (15,3,11) → m_result 5, m_err=0.
- Backpressure: m_ready=0, s_valid held with 6 commands → exactly FIFO_DEPTH=4 accepted, s_ready low thereafter, no capture while FIFO full. Then m_ready=1 → 4 results drain in order, s_ready returns, remaining 2 commands complete.
- Simultaneous push/pop: FIFO holding 2 entries, pop while capture arrives → count stays 2, ordering intact, s_ready never glitches high erroneously.
- Reset mid-flight: 3 ops in flight plus 2 in FIFO, assert reset 1 cycle → all outputs at reset values next cycle, no stale result ever appears. A fresh (1,1,00) → m_result 2.
- Idle bubbles: sparse s_valid (every 3rd cycle) → A/B/op_select return to 0/0/00 between ops, busy falls to 0 after last pop.

Source files
------------

// File: rtl/arith_issue_ctrl.sv
// Issue/capture shell around the fixed-latency arithmetic unit: registers operands,
// tracks each op with a tag pipeline and lands tagged results in a credit-protected FWFT FIFO.
module arith_issue_ctrl #(
    parameter int RESULT_LAT = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_a,
    input  logic [7:0]  s_b,
    input  logic [1:0]  s_op,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [1:0]  op_select,
    input  logic [15:0] result,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_result,
    output logic [1:0]  m_op,
    output logic        m_err,
    output logic        busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = $clog2(RESULT_LAT + 1);
    localparam int SW = CW + LW;

    typedef struct packed {
        logic       vld;
        logic [1:0] op;
        logic       err;
    } tag_t;

    typedef struct packed {
        logic [15:0] res;
        logic [1:0]  op;
        logic        err;
    } entry_t;

    function automatic logic div_by_zero(input logic [1:0] op, input logic [7:0] b);
        return (op == 2'b11) && (b == 8'd0);
    endfunction

    logic [7:0]    a_q, a_d, b_q, b_d;
    logic [1:0]    op_q, op_d;
    tag_t          tag_q [RESULT_LAT];
    tag_t          tag_d [RESULT_LAT];
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [LW-1:0] inflight_d;
    logic          m_valid_q, m_valid_d;
    entry_t        head_q, head_d;
    logic          s_ready_q, s_ready_d;
    logic          busy_q, busy_d;
    logic          accept_s, pop_s, push_s;
    entry_t        new_entry_s;

    // Next-state for issue registers, tag pipeline, FIFO and credit/status flags.
    always_comb begin
        accept_s    = s_valid & s_ready_q;
        pop_s       = m_valid_q & m_ready;
        push_s      = tag_q[RESULT_LAT-1].vld;
        new_entry_s = '{res: result, op: tag_q[RESULT_LAT-1].op, err: tag_q[RESULT_LAT-1].err};

        if (accept_s) begin
            a_d       = s_a;
            b_d       = s_b;
            op_d      = s_op;
            tag_d[0]  = '{vld: 1'b1, op: s_op, err: div_by_zero(s_op, s_b)};
        end else begin
            a_d       = 8'd0;
            b_d       = 8'd0;
            op_d      = 2'b00;
            tag_d[0]  = '0;
        end
        for (int i = 1; i < RESULT_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = new_entry_s;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        inflight_d = '0;
        for (int i = 0; i < RESULT_LAT; i++) begin
            inflight_d = inflight_d + LW'(tag_d[i].vld);
        end

        // The head may be the entry landing this edge when the FIFO drains to it.
        head_d = head_q;
        if (count_d == '0) begin
            head_d = head_q;
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = new_entry_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end

        m_valid_d = (count_d != '0);
        s_ready_d = (SW'(count_d) + SW'(inflight_d)) < SW'(FIFO_DEPTH);
        busy_d    = (inflight_d != '0) || (count_d != '0);
    end

    // State update with synchronous reset discarding in-flight ops and FIFO contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            op_q      <= 2'b00;
            tag_q     <= '{default: '0};
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            head_q    <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            head_q    <= head_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign op_select = op_q;
    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_result  = head_q.res;
    assign m_op      = head_q.op;
    assign m_err     = head_q.err;
    assign busy      = busy_q;

endmodule
